// File: rtl/vga_sprite_layer.sv
// vga_sprite_layer: double-buffered object-layer renderer with per-frame player collision mask
module vga_sprite_layer #(
  parameter int N_OBJ   = 10,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int CLASS_W = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            frame_start,
  input  logic [N_OBJ-1:0]                obj_en,
  input  logic [N_OBJ-1:0][CLASS_W-1:0]   obj_class,
  input  logic [N_OBJ-1:0][X_W-1:0]       obj_left,
  input  logic [N_OBJ-1:0][X_W-1:0]       obj_right,
  input  logic [N_OBJ-1:0][Y_W-1:0]       obj_up,
  input  logic [N_OBJ-1:0][Y_W-1:0]       obj_down,
  input  logic [X_W-1:0]                  ply_left,
  input  logic [X_W-1:0]                  ply_right,
  input  logic [Y_W-1:0]                  ply_up,
  input  logic [Y_W-1:0]                  ply_down,
  input  logic                            pix_valid,
  input  logic [X_W-1:0]                  pix_x,
  input  logic [Y_W-1:0]                  pix_y,
  input  logic [11:0]                     bg_rgb,
  output logic                            out_valid,
  output logic [X_W-1:0]                  out_x,
  output logic [Y_W-1:0]                  out_y,
  output logic [11:0]                     rgb,
  output logic [4:0]                      hit_idx,
  output logic [N_OBJ-1:0]                coll_mask,
  output logic                            coll_any
);
  logic [N_OBJ-1:0]              en_q, en_d;
  logic [N_OBJ-1:0][CLASS_W-1:0] cls_q, cls_d;
  logic [N_OBJ-1:0][X_W-1:0]     lft_q, lft_d, rgt_q, rgt_d;
  logic [N_OBJ-1:0][Y_W-1:0]     upp_q, upp_d, dwn_q, dwn_d;
  logic [X_W-1:0]                pl_q, pl_d, pr_q, pr_d;
  logic [Y_W-1:0]                pu_q, pu_d, pd_q, pd_d;
  logic                          s1_valid_q, s1_valid_d, s1_ply_q, s1_ply_d;
  logic [X_W-1:0]                s1_x_q, s1_x_d;
  logic [Y_W-1:0]                s1_y_q, s1_y_d;
  logic [11:0]                   s1_bg_q, s1_bg_d;
  logic [N_OBJ-1:0]              s1_in_q, s1_in_d, s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;
  logic [N_OBJ-1:0][CLASS_W-1:0] s1_cls_q, s1_cls_d;
  logic                          out_valid_q, out_valid_d, coll_any_q, coll_any_d;
  logic [X_W-1:0]                out_x_q, out_x_d;
  logic [Y_W-1:0]                out_y_q, out_y_d;
  logic [11:0]                   rgb_q, rgb_d, pal;
  logic [4:0]                    hit_q, hit_d, win;
  logic [N_OBJ-1:0]              pend_q, pend_d, coll_q, coll_d, contrib;
  logic [31:0]                   wc;
  logic                          wdx, wdy;
  // Shadow geometry: the active set only changes on a frame_start pulse, so mid-frame updates cannot tear
  always_comb begin
    en_d  = frame_start ? obj_en    : en_q;
    cls_d = frame_start ? obj_class : cls_q;
    lft_d = frame_start ? obj_left  : lft_q;
    rgt_d = frame_start ? obj_right : rgt_q;
    upp_d = frame_start ? obj_up    : upp_q;
    dwn_d = frame_start ? obj_down  : dwn_q;
    pl_d  = frame_start ? ply_left  : pl_q;
    pr_d  = frame_start ? ply_right : pr_q;
    pu_d  = frame_start ? ply_up    : pu_q;
    pd_d  = frame_start ? ply_down  : pd_q;
  end
  // Stage 1: per-slot containment plus bit 2 of the box-relative offset; class travels with the pixel
  always_comb begin
    s1_valid_d = pix_valid;
    s1_x_d     = pix_x;
    s1_y_d     = pix_y;
    s1_bg_d    = bg_rgb;
    s1_cls_d   = cls_q;
    s1_ply_d   = (pix_x >= pl_q) & (pix_x < pr_q) & (pix_y >= pu_q) & (pix_y < pd_q);
    for (int i = 0; i < N_OBJ; i++) begin
      s1_in_d[i] = en_q[i] & (pix_x >= lft_q[i]) & (pix_x < rgt_q[i]) & (pix_y >= upp_q[i]) & (pix_y < dwn_q[i]);
      s1_dx_d[i] = pix_x[2] ^ lft_q[i][2] ^ (pix_x[1:0] < lft_q[i][1:0]);
      s1_dy_d[i] = pix_y[2] ^ upp_q[i][2] ^ (pix_y[1:0] < upp_q[i][1:0]);
    end
  end
  // Stage 2: lowest-index priority, class palette, background fallback and collision accumulation
  always_comb begin
    win = '0;
    wc  = '0;
    wdx = 1'b0;
    wdy = 1'b0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (s1_in_q[i]) begin
        win = 5'(i);
        wc  = 32'(s1_cls_q[i]);
        wdx = s1_dx_q[i];
        wdy = s1_dy_q[i];
      end
    end
    pal = wc == 32'd1 ? 12'hFFF :
          wc == 32'd2 ? (wdx ^ wdy ? 12'h070 : 12'h0A0) :
          wc == 32'd3 ? (wdy ? 12'h066 : 12'h0AA) : 12'h000;
    out_valid_d = s1_valid_q;
    out_x_d     = s1_x_q;
    out_y_d     = s1_y_q;
    rgb_d       = !s1_valid_q ? 12'h000 : |s1_in_q ? pal : s1_bg_q;
    hit_d       = (s1_valid_q & |s1_in_q) ? win : 5'd0;
    contrib     = s1_in_q & {N_OBJ{s1_ply_q & s1_valid_q}};
    pend_d      = frame_start ? '0 : pend_q | contrib;
    coll_d      = frame_start ? pend_q | contrib : coll_q;
    coll_any_d  = |coll_d;
  end
  // All state registers; reset leaves every slot disabled and the player box empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0; cls_q <= '0; lft_q <= '0; rgt_q <= '0; upp_q <= '0; dwn_q <= '0;
      pl_q <= '0; pr_q <= '0; pu_q <= '0; pd_q <= '0;
      s1_valid_q <= 1'b0; s1_x_q <= '0; s1_y_q <= '0; s1_bg_q <= '0; s1_ply_q <= 1'b0;
      s1_in_q <= '0; s1_dx_q <= '0; s1_dy_q <= '0; s1_cls_q <= '0;
      out_valid_q <= 1'b0; out_x_q <= '0; out_y_q <= '0; rgb_q <= '0; hit_q <= '0;
      pend_q <= '0; coll_q <= '0; coll_any_q <= 1'b0;
    end else begin
      en_q <= en_d; cls_q <= cls_d; lft_q <= lft_d; rgt_q <= rgt_d; upp_q <= upp_d; dwn_q <= dwn_d;
      pl_q <= pl_d; pr_q <= pr_d; pu_q <= pu_d; pd_q <= pd_d;
      s1_valid_q <= s1_valid_d; s1_x_q <= s1_x_d; s1_y_q <= s1_y_d; s1_bg_q <= s1_bg_d; s1_ply_q <= s1_ply_d;
      s1_in_q <= s1_in_d; s1_dx_q <= s1_dx_d; s1_dy_q <= s1_dy_d; s1_cls_q <= s1_cls_d;
      out_valid_q <= out_valid_d; out_x_q <= out_x_d; out_y_q <= out_y_d; rgb_q <= rgb_d; hit_q <= hit_d;
      pend_q <= pend_d; coll_q <= coll_d; coll_any_q <= coll_any_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign rgb       = rgb_q;
  assign hit_idx   = hit_q;
  assign coll_mask = coll_q;
  assign coll_any  = coll_any_q;
endmodule

// File: tb/tb_vga_sprite_layer.sv
// tb_vga_sprite_layer: directed scoreboard bench for vga_sprite_layer
module tb_vga_sprite_layer;
  logic clk, rst_n, frame_start, pix_valid;
  logic [9:0] obj_en;
  logic [9:0][1:0] obj_class;
  logic [9:0][9:0] obj_left, obj_right;
  logic [9:0][8:0] obj_up, obj_down;
  logic [9:0] ply_left, ply_right, pix_x, out_x;
  logic [8:0] ply_up, ply_down, pix_y, out_y;
  logic [11:0] bg_rgb, rgb;
  logic out_valid, coll_any;
  logic [4:0] hit_idx;
  logic [9:0] coll_mask;
  typedef struct {int cyc; logic [9:0] x; logic [8:0] y; logic [11:0] rgb; logic [4:0] hit;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;

  vga_sprite_layer #(.N_OBJ(10), .X_W(10), .Y_W(9), .CLASS_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .obj_en(obj_en), .obj_class(obj_class), .obj_left(obj_left), .obj_right(obj_right),
    .obj_up(obj_up), .obj_down(obj_down),
    .ply_left(ply_left), .ply_right(ply_right), .ply_up(ply_up), .ply_down(ply_down),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .bg_rgb(bg_rgb),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .rgb(rgb), .hit_idx(hit_idx),
    .coll_mask(coll_mask), .coll_any(coll_any));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  // monitor: every presented output pixel is matched against the oldest expectation
  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) chk("unexpected_out", 32'(out_x), 32'h3FF);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", 32'(cyc - e.cyc), 32'd2);
        chk("out_x", 32'(out_x), 32'(e.x));
        chk("out_y", 32'(out_y), 32'(e.y));
        chk("rgb", 32'(rgb), 32'(e.rgb));
        chk("hit_idx", 32'(hit_idx), 32'(e.hit));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pix(input int x, input int y, input logic [11:0] bg, input logic [11:0] er, input int eh, input bit fs = 1'b0);
    pix_valid = 1'b1; pix_x = 10'(x); pix_y = 9'(y); bg_rgb = bg; frame_start = fs;
    q.push_back('{cyc, 10'(x), 9'(y), er, 5'(eh)});
    tick();
    pix_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic slot(input int i, input int c, input int l, input int r, input int u, input int d);
    obj_en[i] = 1'b1; obj_class[i] = 2'(c);
    obj_left[i] = 10'(l); obj_right[i] = 10'(r); obj_up[i] = 9'(u); obj_down[i] = 9'(d);
  endtask

  task automatic player(input int l, input int r, input int u, input int d);
    ply_left = 10'(l); ply_right = 10'(r); ply_up = 9'(u); ply_down = 9'(d);
  endtask

  task automatic coll(input string n, input int m, input int a);
    chk({n, "_mask"}, 32'(coll_mask), 32'(m));
    chk({n, "_any"}, 32'(coll_any), 32'(a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0; bg_rgb = '0;
    obj_en = '0; obj_class = '0; obj_left = '0; obj_right = '0; obj_up = '0; obj_down = '0;
    player(0, 0, 0, 0);
    idle(2);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_hit", 32'(hit_idx), 0);
    coll("rst", 0, 0);
    rst_n = 1'b1;
    // no frame_start yet: nothing renders
    slot(0, 1, 10, 20, 10, 20);
    pix(15, 15, 12'h123, 12'h123, 0);
    pix(10, 10, 12'h456, 12'h456, 0);
    idle(3);
    // latch and render; the pixel in the pulse cycle still sees the old (empty) set
    slot(0, 1, 100, 130, 100, 130);
    slot(1, 0, 120, 150, 100, 130);
    pix(125, 110, 12'hABC, 12'hABC, 0, 1'b1);
    pix(125, 110, 12'hABC, 12'hFFF, 0);
    pix(140, 110, 12'hABC, 12'h000, 1);
    pix(130, 110, 12'hABC, 12'h000, 1);
    pix(150, 110, 12'hABC, 12'hABC, 0);
    pix(99, 110, 12'hABC, 12'hABC, 0);
    pix(100, 100, 12'hABC, 12'hFFF, 0);
    pix(125, 130, 12'hABC, 12'hABC, 0);
    pix(129, 129, 12'hABC, 12'hFFF, 0);
    pix_x = 10'd125; pix_y = 9'd110; bg_rgb = 12'hFFF;
    idle(2);
    chk("inv_valid", 32'(out_valid), 0);
    chk("inv_rgb", 32'(rgb), 0);
    chk("inv_hit", 32'(hit_idx), 0);
    // checker and band palettes
    slot(2, 2, 0, 16, 0, 16);
    slot(3, 3, 20, 36, 0, 16);
    pulse();
    pix(0, 0, 12'h111, 12'h0A0, 2);
    pix(4, 0, 12'h111, 12'h070, 2);
    pix(4, 4, 12'h111, 12'h0A0, 2);
    pix(0, 4, 12'h111, 12'h070, 2);
    pix(15, 15, 12'h111, 12'h0A0, 2);
    pix(16, 0, 12'h111, 12'h111, 0);
    pix(20, 0, 12'h111, 12'h0AA, 3);
    pix(20, 4, 12'h111, 12'h066, 3);
    pix(23, 3, 12'h111, 12'h0AA, 3);
    pix(27, 12, 12'h111, 12'h066, 3);
    idle(3);
    // collision: player overlaps slots 0 and 1 only
    obj_left[1] = 10'd105;
    player(110, 112, 110, 112);
    pulse();
    coll("p1", 0, 0);
    pix(111, 111, 12'h222, 12'hFFF, 0);
    pix(5, 5, 12'h222, 12'h0A0, 2);
    pix(112, 111, 12'h222, 12'hFFF, 0);
    idle(3);
    coll("hold", 0, 0);
    player(300, 302, 200, 202);
    pulse();
    coll("p2", 3, 1);
    pix(111, 111, 12'h222, 12'hFFF, 0);
    idle(3);
    player(110, 112, 110, 112);
    pulse();
    coll("p3", 0, 0);
    // tear-free: input change is invisible until the pulse; stage-2 pixel at the pulse is counted
    obj_left[0] = 10'd0;
    pix(50, 110, 12'h321, 12'h321, 0);
    idle(3);
    pix(111, 111, 12'h321, 12'hFFF, 0);
    pulse();
    coll("tear", 3, 1);
    pix(50, 110, 12'h321, 12'hFFF, 0);
    idle(3);
    // asynchronous reset with pend non-zero and pixels in flight
    pix(111, 111, 12'h333, 12'hFFF, 0);
    pix_valid = 1'b1; pix_x = 10'd111; pix_y = 9'd111;
    tick();
    pix_valid = 1'b0;
    #5;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_x", 32'(out_x), 0);
    chk("arst_rgb", 32'(rgb), 0);
    coll("arst", 0, 0);
    #1;
    rst_n = 1'b1;
    pix(111, 111, 12'h0F0, 12'h0F0, 0);
    idle(3);
    pulse();
    coll("post_rst", 0, 0);
    pix(111, 111, 12'h0F0, 12'hFFF, 0);
    idle(4);
    chk("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
